// File: rtl/systolic_ctrl_pkg.sv
// Shared state encoding, feed length and packed-lane indices for the 2x2
// systolic array sequencer.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    DRAIN,
    OUT
  } state_e;

  localparam int FEED_CYCLES = 3;

  // Lane of element (row, col) inside cmd_a, cmd_b and res_c; lane 0 sits in the LSBs.
  localparam int LANE_00 = 0;
  localparam int LANE_01 = 1;
  localparam int LANE_10 = 2;
  localparam int LANE_11 = 3;

endpackage

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew table for the 2x2 array: maps the latched A/B operands and the
// upcoming feed index onto the four registered array edge operands.
module systolic_skew_feeder
  import systolic_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [1:0]      f_i,
  input  logic [4*DW-1:0] a_i,
  input  logic [4*DW-1:0] b_i,
  output logic [DW-1:0]   a0_o,
  output logic [DW-1:0]   a1_o,
  output logic [DW-1:0]   b0_o,
  output logic [DW-1:0]   b1_o
);

  logic [DW-1:0] a0_d, a1_d, b0_d, b1_d;
  logic [DW-1:0] a0_q, a1_q, b0_q, b1_q;

  function automatic logic [DW-1:0] lane(input logic [4*DW-1:0] m, input int idx);
    return m[idx*DW +: DW];
  endfunction

  // load_i/f_i describe the cycle about to start, so the registered feeds line up with FEED.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    a0_d = '0;
    a1_d = '0;
    b0_d = '0;
    b1_d = '0;
    if (load_i) begin
      case (f_i)
        2'd0: begin
          a0_d = lane(a_i, LANE_00);
          b0_d = lane(b_i, LANE_00);
        end
        2'd1: begin
          a0_d = lane(a_i, LANE_01);
          a1_d = lane(a_i, LANE_10);
          b0_d = lane(b_i, LANE_10);
          b1_d = lane(b_i, LANE_01);
        end
        2'd2: begin
          a1_d = lane(a_i, LANE_11);
          b1_d = lane(b_i, LANE_11);
        end
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_q <= '0;
      a1_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
    end else begin
      a0_q <= a0_d;
      a1_q <= a1_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
    end
  end

  assign a0_o = a0_q;
  assign a1_o = a1_q;
  assign b0_o = b0_q;
  assign b1_o = b1_q;

endmodule

// File: rtl/systolic_2x2_ctrl.sv
// Sequencer for the 2x2 systolic multiply array: clear, skewed feed, drain, result.
// Optional DRAIN watchdog and res_err port enabled by SYSTOLIC_CTRL_TIMEOUT_EN.
module systolic_2x2_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MIN_DRAIN = 2
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [4*DW-1:0] cmd_a,
  input  logic [4*DW-1:0] cmd_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [8*DW-1:0] res_c,
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  output logic            res_err,
`endif
  output logic            busy,
  output logic            arr_rst,
  output logic            arr_en,
  output logic [DW-1:0]   arr_a0,
  output logic [DW-1:0]   arr_a1,
  output logic [DW-1:0]   arr_b0,
  output logic [DW-1:0]   arr_b1,
  input  logic [2*DW-1:0] arr_c00,
  input  logic [2*DW-1:0] arr_c01,
  input  logic [2*DW-1:0] arr_c10,
  input  logic [2*DW-1:0] arr_c11,
  input  logic            arr_done
);

  localparam int RW = 2 * DW;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  localparam int D_MAX = (TIMEOUT_CYCLES > MIN_DRAIN) ? TIMEOUT_CYCLES : MIN_DRAIN;
`else
  localparam int D_MAX = MIN_DRAIN;
`endif
  localparam int DCW = $clog2(D_MAX + 2);
  localparam logic [DCW-1:0] D_MIN = DCW'(MIN_DRAIN);
  localparam logic [DCW-1:0] D_SAT = DCW'(D_MAX);
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  localparam logic [DCW-1:0] D_TO  = DCW'(TIMEOUT_CYCLES);
`endif
  localparam logic [1:0] F_LAST = 2'(FEED_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      f_q, f_d;
  logic [DCW-1:0]  d_q, d_d;
  logic [4*DW-1:0] a_q, a_d, b_q, b_d;
  logic            res_valid_q, res_valid_d;
  logic [8*DW-1:0] res_c_q, res_c_d;
  logic            err_q, err_d;
  logic            done_ok;

  // d counts DRAIN cycles including the current one, so the first DRAIN cycle has d=1.
  always_comb begin
    state_d     = state_q;
    f_d         = f_q;
    d_d         = d_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = res_valid_q;
    res_c_d     = res_c_q;
    err_d       = err_q;
    done_ok     = arr_done && (d_q >= D_MIN);
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = CLR;
        end
      end
      CLR: begin
        f_d     = '0;
        state_d = FEED;
      end
      FEED: begin
        if (f_q == F_LAST) begin
          f_d     = '0;
          d_d     = DCW'(1);
          state_d = DRAIN;
        end else begin
          f_d = f_q + 2'd1;
        end
      end
      DRAIN: begin
        if (d_q < D_SAT) d_d = d_q + DCW'(1);
        if (done_ok) begin
          res_c_d[LANE_00*RW +: RW] = arr_c00;
          res_c_d[LANE_01*RW +: RW] = arr_c01;
          res_c_d[LANE_10*RW +: RW] = arr_c10;
          res_c_d[LANE_11*RW +: RW] = arr_c11;
          res_valid_d = 1'b1;
          state_d     = OUT;
        end
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
        else if (d_q >= D_TO) begin
          res_c_d     = '0;
          err_d       = 1'b1;
          res_valid_d = 1'b1;
          state_d     = OUT;
        end
`endif
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          err_d       = 1'b0;
          d_d         = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      f_q         <= '0;
      d_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_c_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      f_q         <= f_d;
      d_q         <= d_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_c_q     <= res_c_d;
      err_q       <= err_d;
    end
  end

  systolic_skew_feeder #(
    .DW (DW)
  ) u_feeder (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_d == FEED),
    .f_i    (f_d),
    .a_i    (a_q),
    .b_i    (b_q),
    .a0_o   (arr_a0),
    .a1_o   (arr_a1),
    .b0_o   (arr_b0),
    .b1_o   (arr_b1)
  );

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign arr_rst   = (state_q == CLR);
  assign arr_en    = (state_q == FEED) || (state_q == DRAIN);
  assign res_valid = res_valid_q;
  assign res_c     = res_c_q;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  assign res_err   = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: doc/systolic_2x2_ctrl.md
Name: systolic_2x2_ctrl

Overview:
Sequencer for the 2x2 weight-stationary-free systolic multiply array. Accepts one 2x2 A and 2x2 B operand set over a valid/ready command port. Clears the array, then streams operands with the diagonal skew, waits for array completion and captures the four products. Presents C = A x B on a valid/ready result port. Sits between the LSTM gate scheduler and the array instance.

Parameters:
DW, 8, operand width; results are 2*DW.
MIN_DRAIN, 2, minimum DRAIN cycles before arr_done is honoured; masks stale done from the previous job.
TIMEOUT_CYCLES, 64, DRAIN watchdog limit; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  operand set valid
cmd_ready  out  1  controller can accept
cmd_a  in  4*DW  {A11,A10,A01,A00}, A00 in LSBs
cmd_b  in  4*DW  {B11,B10,B01,B00}
res_valid  out  1  result valid
res_ready  in  1  consumer accepts
res_c  out  8*DW  {C11,C10,C01,C00}
busy  out  1  high in any state except IDLE
arr_rst  out  1  one-cycle accumulator clear to array
arr_en  out  1  array enable
arr_a0, arr_a1, arr_b0, arr_b1  out  DW each  skewed operand feeds
arr_c00, arr_c01, arr_c10, arr_c11  in  2*DW each  array accumulators
arr_done  in  1  AND of all PE done flags

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high. All flops clear on rst assertion.
- Reset values: state IDLE, cmd_ready=1, res_valid=0, res_c=0, busy=0, arr_rst=0, arr_en=0, all arr_a*/arr_b*=0, counters=0.
- State machine: IDLE -> CLR -> FEED -> DRAIN -> OUT -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch cmd_a/cmd_b and go to CLR.
  - cmd_ready is 0 in every other state.
- CLR: one cycle. arr_rst=1, arr_en=0, operand outputs 0.
- FEED: exactly 3 cycles, arr_en=1, feed-cycle counter f = 0..2. Operand outputs are registered and zero otherwise.
  - f=0: a0=A00, b0=B00, a1=0, b1=0.
  - f=1: a0=A01, b0=B10, a1=A10, b1=B01.
  - f=2: a0=0, b0=0, a1=A11, b1=B11.
- DRAIN:
  - arr_en=1, operand outputs 0, drain counter d increments each cycle.
  - Exit to OUT on the first cycle with arr_done=1 and d>=MIN_DRAIN.
  - On exit, capture arr_c00..c11 into res_c and set res_valid=1.
- OUT:
  - arr_en=0; res_valid held and res_c stable until res_valid&&res_ready.
  - On that handshake: res_valid=0, go to IDLE.
  - No cmd is accepted in OUT, so there is no same-cycle result/command overlap.
- Latency: accept at cycle T, CLR at T+1, FEED at T+2..T+4, DRAIN from T+5. Earliest res_valid is T+5+MIN_DRAIN.
- Arithmetic: no saturation; products and sums wrap modulo 2^(2*DW), as produced by the array.
- Boundary conditions:
  - arr_done high during CLR or FEED is ignored.
  - arr_done low forever stalls in DRAIN (absent the optional feature).
  - res_ready held high in OUT releases after exactly one cycle of res_valid.
  - rst asserted mid-job returns to the reset values immediately; the partial job is discarded and no result is produced.

Optional Feature:
SYSTOLIC_CTRL_TIMEOUT_EN
- Defined:
  - Adds output port res_err (1 bit, reset 0).
  - If d reaches TIMEOUT_CYCLES in DRAIN without a qualifying arr_done, go to OUT with res_c=0 and res_err=1.
  - res_err clears together with res_valid on the result handshake.
- Undefined: no res_err port, no watchdog counter; DRAIN waits indefinitely.

Decomposition:
- Package systolic_ctrl_pkg holds:
  - state enum (IDLE, CLR, FEED, DRAIN, OUT);
  - FEED_CYCLES=3;
  - pack/unpack index constants for cmd_a, cmd_b and res_c lanes.
- One natural sub-module: systolic_skew_feeder. It maps latched A/B and feed count f to the four registered operand outputs, keeping the skew table separate from the FSM.

Test Plan:
- Basic multiply: A=[[1,2],[3,4]], B=[[5,6],[7,8]]; bench uses a behavioural array model. Required response: res_c C00=19, C01=22, C10=43, C11=50; res_valid first at accept+5+MIN_DRAIN.
- Skew check: monitor arr_a0/a1/b0/b1 per FEED cycle against the table, e.g. f=1 gives a0=2, a1=3, b0=7, b1=6. Operands are 0 in CLR and DRAIN; arr_rst is high for exactly one cycle.
- Backpressure: res_ready=0 for 10 cycles in OUT. Required: res_c stable, cmd_ready=0, busy=1. Then res_ready=1 for one cycle, and IDLE follows with cmd_ready=1 the next cycle.
- Back-to-back jobs: second cmd valid while the first is in OUT; it is accepted only after the result handshake. A stale arr_done=1 at DRAIN entry (d<MIN_DRAIN) does not cause early capture.
- Reset mid-FEED: assert rst at f=1. Required: all outputs at reset values asynchronously. No res_valid appears afterwards, and a fresh job then completes correctly.
- Timeout (macro defined): arr_done held 0. Required: at d=64, res_valid=1, res_err=1, res_c=0. Without the macro, the controller remains in DRAIN with busy=1.
